// File: rtl/mux_pkg.sv
// Shared select-code definitions for the 4-input word multiplexer.
package mux_pkg;

    typedef logic [1:0] sel4_t;

    localparam sel4_t SEL_I0 = 2'd0;
    localparam sel4_t SEL_I1 = 2'd1;
    localparam sel4_t SEL_I2 = 2'd2;
    localparam sel4_t SEL_I3 = 2'd3;

endpackage

// File: rtl/mux_4_to_1_comb.sv
// Purely combinational 4:1 word selector; every select code maps to one input.
module mux_4_to_1_comb
    import mux_pkg::*;
#(
    parameter int Size = 64
) (
    input  sel4_t            sel,
    input  logic [Size-1:0]  i0,
    input  logic [Size-1:0]  i1,
    input  logic [Size-1:0]  i2,
    input  logic [Size-1:0]  i3,
    output logic [Size-1:0]  data_o
);

    always_comb begin
        case (sel)
            SEL_I0: data_o = i0;
            SEL_I1: data_o = i1;
            SEL_I2: data_o = i2;
            SEL_I3: data_o = i3;
        endcase
    end

endmodule

// File: rtl/mux_4_to_1.sv
// 4:1 word mux with zero-latency output plus a load-enabled registered copy.
// Optional registered parity output enabled by defining MUX_4_TO_1_PARITY_EN.
module mux_4_to_1
    import mux_pkg::*;
#(
    parameter int Size = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sel4_t            sel,
    input  logic [Size-1:0]  i0,
    input  logic [Size-1:0]  i1,
    input  logic [Size-1:0]  i2,
    input  logic [Size-1:0]  i3,
    input  logic             en_i,
    output logic [Size-1:0]  data_o,
    output logic [Size-1:0]  data_q_o,
    output logic             valid_o,
    output sel4_t            sel_q_o
`ifdef MUX_4_TO_1_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    logic [Size-1:0] data_d, data_q;
    sel4_t           sel_d, sel_q;
    logic            valid_d, valid_q;

    mux_4_to_1_comb #(
        .Size (Size)
    ) u_comb (
        .sel    (sel),
        .i0     (i0),
        .i1     (i1),
        .i2     (i2),
        .i3     (i3),
        .data_o (data_o)
    );

    // Output register stage: load on en_i, otherwise hold; valid is sticky until reset.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (en_i) begin
            data_d  = data_o;
            sel_d   = sel;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= SEL_I0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign data_q_o = data_q;
    assign sel_q_o  = sel_q;
    assign valid_o  = valid_q;

`ifdef MUX_4_TO_1_PARITY_EN
    logic parity_d, parity_q;

    // Parity is computed from the word being loaded so it lands with data_q.
    always_comb begin
        parity_d = parity_q;
        if (en_i) begin
            parity_d = ^data_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1 with an expected-result queue.
module tb_mux_4_to_1;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  sel;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic [63:0] i0, i1, i2, i3;
    logic        en_i;
    logic [63:0] data_o, data_q_o;
    logic        valid_o;
    logic [1:0]  sel_q_o;
`ifdef MUX_4_TO_1_PARITY_EN
    logic        parity_o;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mux_4_to_1 #(.Size(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .en_i     (en_i),
        .data_o   (data_o),
        .data_q_o (data_q_o),
        .valid_o  (valid_o),
        .sel_q_o  (sel_q_o)
`ifdef MUX_4_TO_1_PARITY_EN
        ,
        .parity_o (parity_o)
`endif
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [1:0] s, input logic v);
        exp_t e;
        e.data = d; e.sel = s; e.valid = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"},  data_q_o, e.data);
            check({tag, "_sel"},   {62'd0, sel_q_o}, {62'd0, e.sel});
            check({tag, "_valid"}, {63'd0, valid_o}, {63'd0, e.valid});
`ifdef MUX_4_TO_1_PARITY_EN
            check({tag, "_parity"}, {63'd0, parity_o}, {63'd0, ^e.data});
`endif
        end
    endtask

    initial begin
        logic [63:0] ref_w [4];
        rst_n = 1'b0;
        en_i  = 1'b0;
        sel   = 2'd0;
        i0 = 64'h0123_4567_89AB_CDEF;
        i1 = 64'hFEDC_BA98_7654_3210;
        i2 = 64'hDEAD_BEEF_CAFE_F00D;
        i3 = 64'h0000_0000_FFFF_FFFF;
        ref_w[0] = i0; ref_w[1] = i1; ref_w[2] = i2; ref_w[3] = i3;

        // Combinational select with no clock activity, also under reset.
        for (int k = 0; k < 4; k++) begin
            sel = k[1:0];
            #1;
            check($sformatf("comb_sel%0d", k), data_o, ref_w[k]);
        end
        check("rst_data", data_q_o, 64'd0);
        check("rst_sel",  {62'd0, sel_q_o}, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);

        // Registered load of i2.
        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 2'd2;
        en_i  = 1'b1;
        push(64'hDEAD_BEEF_CAFE_F00D, 2'd2, 1'b1);
        tick();
        pop_check("load_i2");

        // Hold: enable low, inputs and select move.
        en_i = 1'b0;
        sel  = 2'd3;
        i2   = 64'h1;
        for (int k = 0; k < 3; k++) begin
            push(64'hDEAD_BEEF_CAFE_F00D, 2'd2, 1'b1);
            tick();
            pop_check($sformatf("hold%0d", k));
        end
        check("hold_comb", data_o, i3);

        // Back-to-back loads.
        en_i = 1'b1;
        sel = 2'd0; push(i0, 2'd0, 1'b1); tick(); pop_check("b2b_i0");
        sel = 2'd1; push(i1, 2'd1, 1'b1); tick(); pop_check("b2b_i1");
        sel = 2'd3; push(i3, 2'd3, 1'b1); tick(); pop_check("b2b_i3");

        // Parity-relevant words (odd then even popcount).
        i0 = 64'h7; sel = 2'd0; push(64'h7, 2'd0, 1'b1); tick(); pop_check("par_7");
        i0 = 64'h3;             push(64'h3, 2'd0, 1'b1); tick(); pop_check("par_3");

        // Asynchronous reset mid-cycle.
        sel = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", data_q_o, 64'd0);
        check("async_rst_sel",  {62'd0, sel_q_o}, 64'd0);
        check("async_rst_valid", {63'd0, valid_o}, 64'd0);
        sel = 2'd2;
        #1;
        check("rst_comb_follow", data_o, 64'h1);
        tick();
        push(64'd0, 2'd0, 1'b0);
        pop_check("rst_hold_edge");

        // Release with enable low: nothing loads until enable returns.
        @(negedge clk);
        rst_n = 1'b1;
        en_i  = 1'b0;
        push(64'd0, 2'd0, 1'b0); tick(); pop_check("post_rst_idle");
        en_i = 1'b1;
        sel  = 2'd3;
        push(i3, 2'd3, 1'b1); tick(); pop_check("post_rst_load");

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("Finished, got %0d errors", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
